// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 task sequencer slice.
//   seq_state_t : sequencer FSM states
//   owner_t     : which task currently owns the S-memory port
//   S_ADDR_W / S_DATA_W : S-memory address and data widths
package rc4_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST_T1,
        S_WT_T1,
        S_ST_T2A,
        S_WT_T2A,
        S_ST_T2B,
        S_WT_T2B,
        S_DONE,
        S_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_T1   = 2'd1,
        OWN_T2A  = 2'd2,
        OWN_T2B  = 2'd3
    } owner_t;

endpackage

// File: rtl/s_mem_port_mux.sv
// Owner-indexed S-memory port mux (purely combinational).
//   owner_i                 : current owner (NONE/T1/T2A/T2B)
//   wr_en_*/addr_*/data_*_i : per-task write requests
//   s_wr_en_o/s_addr_o/s_data_o : muxed S-memory port, all zero when no owner
module s_mem_port_mux
    import rc4_pkg::*;
(
    input  logic [1:0]          owner_i,
    input  logic                wr_en_t1_i,
    input  logic [S_ADDR_W-1:0] addr_t1_i,
    input  logic [S_DATA_W-1:0] data_t1_i,
    input  logic                wr_en_t2a_i,
    input  logic [S_ADDR_W-1:0] addr_t2a_i,
    input  logic [S_DATA_W-1:0] data_t2a_i,
    input  logic                wr_en_t2b_i,
    input  logic [S_ADDR_W-1:0] addr_t2b_i,
    input  logic [S_DATA_W-1:0] data_t2b_i,
    output logic                s_wr_en_o,
    output logic [S_ADDR_W-1:0] s_addr_o,
    output logic [S_DATA_W-1:0] s_data_o
);

    always_comb begin
        s_wr_en_o = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        case (owner_t'(owner_i))
            OWN_T1: begin
                s_wr_en_o = wr_en_t1_i;
                s_addr_o  = addr_t1_i;
                s_data_o  = data_t1_i;
            end
            OWN_T2A: begin
                s_wr_en_o = wr_en_t2a_i;
                s_addr_o  = addr_t2a_i;
                s_data_o  = data_t2a_i;
            end
            OWN_T2B: begin
                s_wr_en_o = wr_en_t2b_i;
                s_addr_o  = addr_t2b_i;
                s_data_o  = data_t2b_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/task_sequencer.sv
// RC4 task sequencer: runs S-init (T1), key schedule (T2A) and decrypt (T2B)
// in order, hands the S-memory port to the active task and aborts to ERR if a
// task does not finish within TIMEOUT_CYCLES wait cycles.
//   clk, rst              : clock, synchronous active-high reset
//   go                    : start a full run (only honoured when not busy)
//   start_t1/t2a/t2b      : one-cycle task start pulses
//   fin_t1/t2a/t2b        : one-cycle task finish strobes
//   wr_en_*/addr_*/data_* : per-task S-memory requests
//   s_wr_en/s_addr/s_data : muxed S-memory port
//   busy, done_strobe, err, owner : status
module task_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    output logic                start_t1,
    output logic                start_t2a,
    output logic                start_t2b,
    input  logic                fin_t1,
    input  logic                fin_t2a,
    input  logic                fin_t2b,
    input  logic                wr_en_t1,
    input  logic [S_ADDR_W-1:0] addr_t1,
    input  logic [S_DATA_W-1:0] data_t1,
    input  logic                wr_en_t2a,
    input  logic [S_ADDR_W-1:0] addr_t2a,
    input  logic [S_DATA_W-1:0] data_t2a,
    input  logic                wr_en_t2b,
    input  logic [S_ADDR_W-1:0] addr_t2b,
    input  logic [S_DATA_W-1:0] data_t2b,
    output logic                s_wr_en,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [S_DATA_W-1:0] s_data,
    output logic                busy,
    output logic                done_strobe,
    output logic                err,
    output logic [1:0]          owner
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Count value seen in the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state_q;
    owner_t           owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_t1_q, start_t2a_q, start_t2b_q;
    logic             busy_q, done_q, err_q;

    // Outputs are registered alongside the state so they line up exactly
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            start_t1_q  <= 1'b0;
            start_t2a_q <= 1'b0;
            start_t2b_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_t1_q  <= 1'b0;
            start_t2a_q <= 1'b0;
            start_t2b_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (go) begin
                        state_q    <= S_ST_T1;
                        owner_q    <= OWN_T1;
                        start_t1_q <= 1'b1;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                    end else if (state_q == S_DONE) begin
                        state_q <= S_IDLE;
                    end
                end
                S_ST_T1: begin
                    state_q <= S_WT_T1;
                    cnt_q   <= '0;
                end
                S_WT_T1: begin
                    if (fin_t1) begin
                        state_q     <= S_ST_T2A;
                        owner_q     <= OWN_T2A;
                        start_t2a_q <= 1'b1;
                        cnt_q       <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ERR;
                        owner_q <= OWN_NONE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ST_T2A: begin
                    state_q <= S_WT_T2A;
                    cnt_q   <= '0;
                end
                S_WT_T2A: begin
                    if (fin_t2a) begin
                        state_q     <= S_ST_T2B;
                        owner_q     <= OWN_T2B;
                        start_t2b_q <= 1'b1;
                        cnt_q       <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ERR;
                        owner_q <= OWN_NONE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ST_T2B: begin
                    state_q <= S_WT_T2B;
                    cnt_q   <= '0;
                end
                S_WT_T2B: begin
                    if (fin_t2b) begin
                        state_q <= S_DONE;
                        owner_q <= OWN_NONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ERR;
                        owner_q <= OWN_NONE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    owner_q <= OWN_NONE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign start_t1    = start_t1_q;
    assign start_t2a   = start_t2a_q;
    assign start_t2b   = start_t2b_q;
    assign busy        = busy_q;
    assign done_strobe = done_q;
    assign err         = err_q;
    assign owner       = owner_q;

    s_mem_port_mux u_mux (
        .owner_i     (owner_q),
        .wr_en_t1_i  (wr_en_t1),
        .addr_t1_i   (addr_t1),
        .data_t1_i   (data_t1),
        .wr_en_t2a_i (wr_en_t2a),
        .addr_t2a_i  (addr_t2a),
        .data_t2a_i  (data_t2a),
        .wr_en_t2b_i (wr_en_t2b),
        .addr_t2b_i  (addr_t2b),
        .data_t2b_i  (data_t2b),
        .s_wr_en_o   (s_wr_en),
        .s_addr_o    (s_addr),
        .s_data_o    (s_data)
    );

endmodule

// File: tb/tb_task_sequencer.sv
module tb_task_sequencer;

    logic       clk, rst, go;
    logic       fin_t1, fin_t2a, fin_t2b;
    logic       wr_en_t1, wr_en_t2a, wr_en_t2b;
    logic [7:0] addr_t1, addr_t2a, addr_t2b;
    logic [7:0] data_t1, data_t2a, data_t2b;

    // dut_a: default timeout, dut_b: TIMEOUT_CYCLES=8. Both share inputs.
    logic       a_st1, a_st2a, a_st2b, a_busy, a_done, a_err, a_swe;
    logic [7:0] a_sa, a_sd;
    logic [1:0] a_owner;
    logic       b_st1, b_st2a, b_st2b, b_busy, b_done, b_err, b_swe;
    logic [7:0] b_sa, b_sd;
    logic [1:0] b_owner;
    logic [5:0] a_flags, b_flags;

    assign a_flags = {a_st1, a_st2a, a_st2b, a_done, a_busy, a_err};
    assign b_flags = {b_st1, b_st2a, b_st2b, b_done, b_busy, b_err};

    int n_checks = 0;
    int n_fail   = 0;

    task_sequencer dut_a (
        .clk(clk), .rst(rst), .go(go),
        .start_t1(a_st1), .start_t2a(a_st2a), .start_t2b(a_st2b),
        .fin_t1(fin_t1), .fin_t2a(fin_t2a), .fin_t2b(fin_t2b),
        .wr_en_t1(wr_en_t1), .addr_t1(addr_t1), .data_t1(data_t1),
        .wr_en_t2a(wr_en_t2a), .addr_t2a(addr_t2a), .data_t2a(data_t2a),
        .wr_en_t2b(wr_en_t2b), .addr_t2b(addr_t2b), .data_t2b(data_t2b),
        .s_wr_en(a_swe), .s_addr(a_sa), .s_data(a_sd),
        .busy(a_busy), .done_strobe(a_done), .err(a_err), .owner(a_owner)
    );

    task_sequencer #(.TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .go(go),
        .start_t1(b_st1), .start_t2a(b_st2a), .start_t2b(b_st2b),
        .fin_t1(fin_t1), .fin_t2a(fin_t2a), .fin_t2b(fin_t2b),
        .wr_en_t1(wr_en_t1), .addr_t1(addr_t1), .data_t1(data_t1),
        .wr_en_t2a(wr_en_t2a), .addr_t2a(addr_t2a), .data_t2a(data_t2a),
        .wr_en_t2b(wr_en_t2b), .addr_t2b(addr_t2b), .data_t2b(data_t2b),
        .s_wr_en(b_swe), .s_addr(b_sa), .s_data(b_sd),
        .busy(b_busy), .done_strobe(b_done), .err(b_err), .owner(b_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        go = 0; fin_t1 = 0; fin_t2a = 0; fin_t2b = 0;
        wr_en_t1 = 0; wr_en_t2a = 0; wr_en_t2b = 0;
        addr_t1 = 0; addr_t2a = 0; addr_t2b = 0;
        data_t1 = 0; data_t2a = 0; data_t2b = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; go = 1; fin_t1 = 1; fin_t2a = 1; fin_t2b = 1;
        wr_en_t1 = 1; addr_t1 = 8'h11; data_t1 = 8'h22;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                rst = 0; go = 0; fin_t1 = 0; fin_t2a = 0; fin_t2b = 0;
            end
            tick();
            n_checks++;
            if ({a_flags, a_owner, a_swe, a_sa, a_sd} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_a[%0d]: got flags=%b owner=%0d we=%b a=%h d=%h, want all 0",
                         k, a_flags, a_owner, a_swe, a_sa, a_sd);
            end
            n_checks++;
            if ({b_flags, b_owner, b_swe, b_sa, b_sd} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_b[%0d]: got flags=%b owner=%0d we=%b a=%h d=%h, want all 0",
                         k, b_flags, b_owner, b_swe, b_sa, b_sd);
            end
        end
        clear_inputs();
    endtask

    task automatic test_nominal();
        logic [5:0] ef;
        logic [1:0] eo;
        do_reset();
        for (int c = 0; c <= 52; c++) begin
            go = (c == 0); fin_t1 = (c == 10); fin_t2a = (c == 30); fin_t2b = (c == 50);
            ef = {c == 1, c == 11, c == 31, c == 51, (c >= 1 && c <= 50), 1'b0};
            eo = (c >= 1 && c <= 10) ? 2'd1 : (c >= 11 && c <= 30) ? 2'd2 :
                 (c >= 31 && c <= 50) ? 2'd3 : 2'd0;
            n_checks++;
            if (a_flags !== ef || a_owner !== eo) begin
                n_fail++;
                $display("FAIL nominal c=%0d: got flags=%b owner=%0d, want flags=%b owner=%0d",
                         c, a_flags, a_owner, ef, eo);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_mux_isolation();
        do_reset();
        wr_en_t1 = 1; addr_t1 = 8'h55; data_t1 = 8'hAA;
        wr_en_t2a = 0; addr_t2a = 8'h12; data_t2a = 8'h34;
        wr_en_t2b = 1; addr_t2b = 8'h99; data_t2b = 8'h66;
        #1;
        n_checks++;
        if ({a_swe, a_sa, a_sd} !== 17'd0) begin
            n_fail++;
            $display("FAIL mux_none: got we=%b a=%h d=%h, want 0/00/00", a_swe, a_sa, a_sd);
        end
        go = 1; tick(); go = 0;            // ST_T1
        n_checks++;
        if (a_owner !== 2'd1 || {a_swe, a_sa, a_sd} !== {1'b1, 8'h55, 8'hAA}) begin
            n_fail++;
            $display("FAIL mux_t1: got owner=%0d we=%b a=%h d=%h, want 1/1/55/aa",
                     a_owner, a_swe, a_sa, a_sd);
        end
        tick();                            // WT_T1
        fin_t1 = 1; tick(); fin_t1 = 0;    // ST_T2A
        n_checks++;
        if (a_owner !== 2'd2 || a_swe !== 1'b0 || a_sa !== 8'h12 || a_sd !== 8'h34) begin
            n_fail++;
            $display("FAIL mux_t2a: got owner=%0d we=%b a=%h d=%h, want 2/0/12/34",
                     a_owner, a_swe, a_sa, a_sd);
        end
        wr_en_t2a = 1; #1;
        n_checks++;
        if (a_swe !== 1'b1) begin
            n_fail++;
            $display("FAIL mux_t2a_we: got we=%b, want 1", a_swe);
        end
        clear_inputs();
    endtask

    task automatic test_stray_strobes();
        do_reset();
        go = 1; tick(); go = 0;            // ST_T1
        fin_t1 = 1; tick(); fin_t1 = 0;    // must be WT_T1, not ST_T2A
        n_checks++;
        if (a_st2a !== 1'b0 || a_owner !== 2'd1 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_fin_in_st: got st2a=%b owner=%0d busy=%b, want 0/1/1",
                     a_st2a, a_owner, a_busy);
        end
        fin_t2b = 1; fin_t2a = 1; tick(); fin_t2b = 0; fin_t2a = 0;
        n_checks++;
        if (a_st2a !== 1'b0 || a_st2b !== 1'b0 || a_done !== 1'b0 || a_owner !== 2'd1) begin
            n_fail++;
            $display("FAIL stray_wrong_fin: got st2a=%b st2b=%b done=%b owner=%0d, want 0/0/0/1",
                     a_st2a, a_st2b, a_done, a_owner);
        end
        tick();
        fin_t1 = 1; tick(); fin_t1 = 0;
        n_checks++;
        if (a_st2a !== 1'b1 || a_owner !== 2'd2) begin
            n_fail++;
            $display("FAIL stray_then_real: got st2a=%b owner=%0d, want 1/2", a_st2a, a_owner);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic [5:0] ef;
        logic [1:0] eo;
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            go = (c == 0); fin_t1 = (c == 2);
            ef = {c == 1, c == 3, 1'b0, 1'b0, (c >= 1 && c <= 11), c >= 12};
            eo = (c >= 1 && c <= 2) ? 2'd1 : (c >= 3 && c <= 11) ? 2'd2 : 2'd0;
            n_checks++;
            if (b_flags !== ef || b_owner !== eo) begin
                n_fail++;
                $display("FAIL timeout c=%0d: got flags=%b owner=%0d, want flags=%b owner=%0d",
                         c, b_flags, b_owner, ef, eo);
            end
            tick();
        end
        go = 1; tick(); go = 0;
        n_checks++;
        if (b_st1 !== 1'b1 || b_err !== 1'b0 || b_owner !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_recover: got st1=%b err=%b owner=%0d, want 1/0/1",
                     b_st1, b_err, b_owner);
        end
        clear_inputs();
    endtask

    task automatic test_boundary();
        logic [5:0] ef;
        int dones = 0;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            go = (c == 0 || c == 5 || c == 12);
            fin_t1 = (c == 9); fin_t2a = (c == 18); fin_t2b = (c == 27);
            ef = {c == 1, c == 10, c == 19, c == 28, (c >= 1 && c <= 27), 1'b0};
            if (b_done === 1'b1) dones++;
            n_checks++;
            if (b_flags !== ef) begin
                n_fail++;
                $display("FAIL boundary c=%0d: got flags=%b, want %b", c, b_flags, ef);
            end
            tick();
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL boundary_done_count: got %0d, want 1", dones);
        end
        clear_inputs();
    endtask

    task automatic test_reset_midrun();
        logic [5:0] ef;
        logic [1:0] eo;
        logic [7:0] ea;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            go = (c == 0); fin_t1 = (c == 2); fin_t2a = (c == 4);
            tick();
        end
        n_checks++;
        if (a_owner !== 2'd3 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre: got owner=%0d busy=%b, want 3/1", a_owner, a_busy);
        end
        rst = 1; go = 1; fin_t1 = 1; fin_t2b = 1;
        wr_en_t2b = 1; addr_t2b = 8'h77; data_t2b = 8'h88;
        for (int k = 0; k < 2; k++) begin
            tick();
            rst = 0; go = 0; fin_t1 = 0; fin_t2b = 0;
            n_checks++;
            if ({a_flags, a_owner, a_swe, a_sa, a_sd} !== 25'd0) begin
                n_fail++;
                $display("FAIL midrun_rst[%0d]: got flags=%b owner=%0d we=%b a=%h d=%h, want all 0",
                         k, a_flags, a_owner, a_swe, a_sa, a_sd);
            end
        end
        for (int c = 0; c <= 11; c++) begin
            go = (c == 0); fin_t1 = (c == 3); fin_t2a = (c == 6); fin_t2b = (c == 9);
            ef = {c == 1, c == 4, c == 7, c == 10, (c >= 1 && c <= 9), 1'b0};
            eo = (c >= 1 && c <= 3) ? 2'd1 : (c >= 4 && c <= 6) ? 2'd2 :
                 (c >= 7 && c <= 9) ? 2'd3 : 2'd0;
            ea = (eo == 2'd3) ? 8'h77 : 8'h00;
            n_checks++;
            if (a_flags !== ef || a_owner !== eo || a_sa !== ea) begin
                n_fail++;
                $display("FAIL midrun_replay c=%0d: got flags=%b owner=%0d addr=%h, want flags=%b owner=%0d addr=%h",
                         c, a_flags, a_owner, a_sa, ef, eo, ea);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_nominal();
        test_mux_isolation();
        test_stray_strobes();
        test_timeout();
        test_boundary();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/task_sequencer.md
TASK_SEQUENCER -- requirements
Module: task_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 4096, max cycles any one task may stay in its WAIT state before error.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 go  in  1  request full RC4 run (init S, key schedule, decrypt); sampled in IDLE, DONE, ERR only.
REQ-005 start_t1 / start_t2a / start_t2b  out  1 each  one-cycle start pulse to S-init, key-schedule and decrypt tasks.
REQ-006 fin_t1 / fin_t2a / fin_t2b  in  1 each  one-cycle finish strobes from those tasks.
REQ-007 wr_en_t1, addr_t1, data_t1 (and _t2a, _t2b)  in  1/8/8  per-task S-memory write enable, address, write data.
REQ-008 s_wr_en, s_addr, s_data  out  1/8/8  muxed S-memory port.
REQ-009 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-010 done_strobe  out  1  one-cycle pulse after decrypt finishes.
REQ-011 err  out  1  sticky timeout flag.
REQ-012 owner  out  2  current S-memory owner (NONE=0, T1=1, T2A=2, T2B=3).

Function
REQ-013 FSM states: IDLE, ST_T1, WT_T1, ST_T2A, WT_T2A, ST_T2B, WT_T2B, DONE, ERR.
REQ-014 IDLE/DONE/ERR with go=1 -> ST_T1 next cycle; without go, DONE -> IDLE, IDLE and ERR hold.
REQ-015 ST_x -> WT_x unconditionally; start_x is high exactly while in ST_x.
REQ-016 Latency: go sampled at edge N gives start_t1=1 in cycle N+1.
REQ-017 WT_T1 with fin_t1 -> ST_T2A; WT_T2A with fin_t2a -> ST_T2B; WT_T2B with fin_t2b -> DONE.
REQ-018 done_strobe high only in DONE, for exactly one cycle.
REQ-019 owner register is set on entry to ST_x and holds through WT_x; it is NONE in IDLE, DONE and ERR.
REQ-020 The S-memory port mux is combinational from the owner register. With owner NONE: s_wr_en=0, s_addr=0, s_data=0.
REQ-021 Inputs from a non-owning task never reach the S-memory port.
REQ-022 Finish strobes are ignored in ST_x states, and from any task other than the one being waited on.
REQ-023 go is ignored while busy; a go pulse in the busy window is not queued.
REQ-024 Timeout counter width is clog2(TIMEOUT_CYCLES+1). It clears in every ST_x and increments each WT_x cycle.
REQ-025 In WT_x, if the count equals TIMEOUT_CYCLES-1 and fin_x=0, the next state is ERR and err is set. A fin_x in that same cycle wins, and the FSM advances normally.
REQ-026 err stays set in ERR. It clears on the cycle ST_T1 is entered from go, or on rst.
REQ-027 done_strobe is never asserted on a timed-out run.

Reset
REQ-028 rst, including mid-operation, forces IDLE next cycle: owner=NONE, counter=0.
REQ-029 While in reset and the cycle after, all outputs are 0: start_*, s_wr_en, s_addr, s_data, busy, done_strobe, err.
REQ-030 rst has priority over go and over all fin_* inputs in the same cycle.

Structure
REQ-031 Shared package rc4_pkg holds the FSM state enum, the owner enum (OWN_NONE, OWN_T1, OWN_T2A, OWN_T2B) and S_ADDR_W=8, S_DATA_W=8.
REQ-032 One sub-module, s_mem_port_mux, holds the purely combinational owner-indexed mux of REQ-020/021.
REQ-033 The FSM and the timeout counter are in task_sequencer itself.

Verification
REQ-034 Nominal run: go at cycle 0; fin_t1 at 10, fin_t2a at 30, fin_t2b at 50. Expect start_t1 at 1, start_t2a at 11, start_t2b at 31, done_strobe at 51, IDLE at 52 with busy=0.
REQ-035 Mux isolation: owner=T2A, wr_en_t1=1, addr_t1=0x55, wr_en_t2a=0, addr_t2a=0x12. Expect s_wr_en=0, s_addr=0x12.
REQ-036 Stray strobes: fin_t2b pulsed in WT_T1 and fin_t1 pulsed in ST_T1. Expect no state change, owner stays T1.
REQ-037 Timeout: TIMEOUT_CYCLES=8, fin_t2a never arrives. Expect ERR 8 cycles after entering WT_T2A, err=1, owner=0, no done_strobe. Then go -> err=0, start_t1 next cycle.
REQ-038 Boundary: fin_x on the final timeout cycle -> normal advance, err=0. Second go during busy -> ignored, exactly one done_strobe.
REQ-039 Reset mid-run: rst in WT_T2B -> next cycle IDLE, all outputs 0. A subsequent go replays the full sequence from start_t1.
